// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined LC-3b core.
// Owns the PC and applies the predictor's next-PC select. Runs the
// instruction-memory read handshake and fills the IF/ID register.
// A stalled response is parked in a hold buffer. A flush that lands while
// a read is outstanding is absorbed by draining that read before redirecting.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   pcmux_sel               next-PC select (000 pc+2, 001 br_add_out,
//                           010 reg_target, 011 trap_target, 100 predicted_pc,
//                           101 recovery_pc, 11x pc+2)
//   predicted_pc, br_add_out, reg_target, trap_target, recovery_pc
//                           candidate next-PC values
//   flush, stall            squash/redirect, downstream back-pressure
//   imem_read/address       read request, held until imem_resp
//   imem_rdata/resp         instruction word, 1-cycle completion pulse
//   if_valid/pc/pc_plus2/ir IF/ID pipeline register
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  pcmux_sel,
  input  logic [15:0] predicted_pc,
  input  logic [15:0] br_add_out,
  input  logic [15:0] reg_target,
  input  logic [15:0] trap_target,
  input  logic [15:0] recovery_pc,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic [15:0] if_ir
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [15:0] ir;
  } ifid_t;

  state_t      state, state_nxt;
  ifid_t       ifid;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] pc_sel;
  logic [15:0] pc_next;
  logic [15:0] hold_buf;
  logic [15:0] redirect;

  // next-PC mux; targets are word aligned, so bit 0 is always dropped
  assign pc_inc = pc + 16'd2;

  always_comb begin
    pc_sel = pc_inc;
    case (pcmux_sel)
      3'b001:  pc_sel = br_add_out;
      3'b010:  pc_sel = reg_target;
      3'b011:  pc_sel = trap_target;
      3'b100:  pc_sel = predicted_pc;
      3'b101:  pc_sel = recovery_pc;
      default: pc_sel = pc_inc;
    endcase
    pc_next = {pc_sel[15:1], 1'b0};
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  // next-state logic; flush always outranks stall
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (flush && !imem_resp)      state_nxt = DRAIN;
        else if (!flush && imem_resp && stall) state_nxt = HOLD;
      end
      HOLD:    if (flush || !stall) state_nxt = FETCH;
      DRAIN:   if (imem_resp)       state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // outputs; a request is never raised while reset is held, and the
  // address is the PC itself so it stays put until the response arrives
  always_comb begin
    imem_read    = reset_n && (state != HOLD);
    imem_address = pc;
  end

  // PC, hold buffer, redirect register and IF/ID
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      hold_buf <= '0;
      redirect <= '0;
      ifid     <= '0;
    end else begin
      // default: bubble unless stalled (flush kills the slot regardless)
      if (flush || !stall) ifid.valid <= 1'b0;
      case (state)
        FETCH: begin
          if (flush) begin
            // response in the same cycle is dropped; otherwise park the
            // target until the in-flight read drains
            if (imem_resp) pc       <= pc_next;
            else           redirect <= pc_next;
          end else if (imem_resp) begin
            if (stall) hold_buf <= imem_rdata;
            else begin
              ifid <= '{valid: 1'b1, pc: pc, pc_plus2: pc_inc, ir: imem_rdata};
              pc   <= pc_next;
            end
          end
        end
        HOLD: begin
          if (flush) pc <= pc_next;
          else if (!stall) begin
            ifid <= '{valid: 1'b1, pc: pc, pc_plus2: pc_inc, ir: hold_buf};
            pc   <= pc_next;
          end
        end
        DRAIN: begin
          // last flush wins, including one coinciding with the drained resp
          if (imem_resp) pc       <= flush ? pc_next : redirect;
          else if (flush) redirect <= pc_next;
        end
        default: ;
      endcase
    end
  end

  assign if_valid    = ifid.valid;
  assign if_pc       = ifid.pc;
  assign if_pc_plus2 = ifid.pc_plus2;
  assign if_ir       = ifid.ir;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a negedge memory model/scoreboard plus directed
// sequences for reset, pipelining, HOLD, DRAIN, redirects and wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  pcmux_sel = 3'b000;
  logic [15:0] predicted_pc = '0, br_add_out = '0, reg_target = '0;
  logic [15:0] trap_target = '0, recovery_pc = '0;
  logic        flush = 1'b0, stall = 1'b0;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        if_valid;
  logic [15:0] if_pc, if_pc_plus2, if_ir;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { logic [15:0] pc; logic [15:0] ir; } exp_t;
  exp_t sb[$];

  // memory model state
  int          waits = 0;
  int          cnt = 0;
  bit          busy = 1'b0;
  bit          squashed = 1'b0;
  logic [15:0] addr_lat = '0;
  logic [15:0] exp_next = '0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .pcmux_sel(pcmux_sel),
    .predicted_pc(predicted_pc), .br_add_out(br_add_out),
    .reg_target(reg_target), .trap_target(trap_target),
    .recovery_pc(recovery_pc), .flush(flush), .stall(stall),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2),
    .if_ir(if_ir)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // reference next-PC mux
  function automatic logic [15:0] nxt(input logic [2:0] s, input logic [15:0] p);
    logic [15:0] r;
    case (s)
      3'b001:  r = br_add_out;
      3'b010:  r = reg_target;
      3'b011:  r = trap_target;
      3'b100:  r = predicted_pc;
      3'b101:  r = recovery_pc;
      default: r = p + 16'd2;
    endcase
    return {r[15:1], 1'b0};
  endfunction

  // memory model + scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      busy      = 1'b0;
      imem_resp = 1'b0;
      sb.delete();
      exp_next  = 16'h0000;
    end else begin
      // consumer takes IF/ID whenever it is valid and not held/squashed
      if (if_valid && !stall && !flush) begin
        if (sb.size() == 0) chk("spurious_valid", 16'd1, 16'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_ir", if_ir, e.ir);
          chk("if_pc_plus2", if_pc_plus2, e.pc + 16'd2);
        end
      end
      if (flush) sb.delete();
      if (imem_read) begin
        if (!busy) begin
          busy     = 1'b1;
          cnt      = waits;
          addr_lat = imem_address;
          squashed = 1'b0;
          chk("req_addr", imem_address, exp_next);
        end else chk("addr_stable", imem_address, addr_lat);
        if (flush) squashed = 1'b1;
        if (cnt == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = 16'h1000 + addr_lat;
          busy       = 1'b0;
          if (!squashed) begin
            sb.push_back('{pc: addr_lat, ir: 16'h1000 + addr_lat});
            exp_next = nxt(pcmux_sel, addr_lat);
          end
        end else begin
          imem_resp = 1'b0;
          cnt--;
        end
      end else begin
        imem_resp = 1'b0;
        if (busy) begin
          chk("req_cancelled", 16'd1, 16'd0);
          busy = 1'b0;
        end
      end
      if (flush) exp_next = nxt(pcmux_sel, addr_lat);
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_read", 16'(imem_read), 16'd0);
    chk("rst_addr", imem_address, 16'h0000);
    chk("rst_valid", 16'(if_valid), 16'd0);
    chk("rst_if_pc", if_pc, 16'h0000);
    chk("rst_pc_plus2", if_pc_plus2, 16'h0000);
    chk("rst_if_ir", if_ir, 16'h0000);
    reset_n = 1'b1;

    // zero-wait streaming
    smp();
    chk("s_read", 16'(imem_read), 16'd1);
    chk("s_addr0", imem_address, 16'h0000);
    chk("s_valid0", 16'(if_valid), 16'd0);
    step(); smp();
    chk("s_addr1", imem_address, 16'h0002);
    chk("s_valid1", 16'(if_valid), 16'd1);
    chk("s_pc1", if_pc, 16'h0000);
    step(); smp();
    chk("s_addr2", imem_address, 16'h0004);
    chk("s_pc2", if_pc, 16'h0002);
    chk("s_ir2", if_ir, 16'h1002);

    // predicted target alignment and FFFE wrap
    step(); pcmux_sel = 3'b100; predicted_pc = 16'h0301; smp();
    step(); predicted_pc = 16'hFFFE; smp();
    chk("pred_addr", imem_address, 16'h0300);
    step(); pcmux_sel = 3'b000; smp();
    chk("ffe_addr", imem_address, 16'hFFFE);
    step(); smp();
    chk("wrap_addr", imem_address, 16'h0000);
    chk("wrap_if_pc", if_pc, 16'hFFFE);
    chk("wrap_plus2", if_pc_plus2, 16'h0000);

    // flush coinciding with a response
    step(); pcmux_sel = 3'b001; br_add_out = 16'h0120; flush = 1'b1; smp();
    step(); flush = 1'b0; pcmux_sel = 3'b000; smp();
    chk("fr_valid", 16'(if_valid), 16'd0);
    chk("fr_addr", imem_address, 16'h0120);
    step(); smp();
    chk("fr_valid2", 16'(if_valid), 16'd1);
    chk("fr_pc", if_pc, 16'h0120);

    // two wait states, stall over the response for 3 more cycles
    step(); waits = 2;
    begin
      int i;
      for (i = 0; i < 20 && !(busy && cnt == 0); i++) begin
        smp(); step();
      end
      if (i == 20) chk("hold_sync_timeout", 16'd1, 16'd0);
    end
    stall = 1'b1; smp();
    chk("h_resp_read", 16'(imem_read), 16'd1);
    for (int k = 0; k < 3; k++) begin
      step(); smp();
      chk("h_read", 16'(imem_read), 16'd0);
      chk("h_addr", imem_address, 16'h0124);
    end
    step(); stall = 1'b0; smp();
    chk("h_rel_read", 16'(imem_read), 16'd0);
    step(); smp();
    chk("h_next_read", 16'(imem_read), 16'd1);
    chk("h_next_addr", imem_address, 16'h0126);
    chk("h_valid", 16'(if_valid), 16'd1);
    chk("h_ir", if_ir, 16'h1124);
    step(); waits = 0; smp();
    step(); smp();

    // flush while a 3-wait read is outstanding -> DRAIN
    step(); flush = 1'b1; pcmux_sel = 3'b011; trap_target = 16'h0010; smp();
    step(); flush = 1'b0; pcmux_sel = 3'b000; waits = 3; smp();
    chk("d_valid0", 16'(if_valid), 16'd0);
    chk("d_addr0", imem_address, 16'h0010);
    step(); flush = 1'b1; pcmux_sel = 3'b101; recovery_pc = 16'h0040; smp();
    step(); flush = 1'b0; pcmux_sel = 3'b000; smp();
    chk("d_valid1", 16'(if_valid), 16'd0);
    chk("d_read1", 16'(imem_read), 16'd1);
    chk("d_addr1", imem_address, 16'h0010);
    step(); waits = 0; smp();
    chk("d_valid2", 16'(if_valid), 16'd0);
    chk("d_addr2", imem_address, 16'h0010);
    step(); smp();
    chk("d_addr3", imem_address, 16'h0040);
    chk("d_valid3", 16'(if_valid), 16'd0);
    step(); smp();
    chk("d_valid4", 16'(if_valid), 16'd1);
    chk("d_pc4", if_pc, 16'h0040);

    // async reset while draining
    step(); waits = 5; smp();
    step(); flush = 1'b1; pcmux_sel = 3'b101; recovery_pc = 16'h0200; smp();
    step(); flush = 1'b0; pcmux_sel = 3'b000; smp();
    chk("r_drain_read", 16'(imem_read), 16'd1);
    chk("r_drain_addr", imem_address, 16'h0044);
    step(); #2 reset_n = 1'b0; #1;
    chk("r_read", 16'(imem_read), 16'd0);
    chk("r_addr", imem_address, 16'h0000);
    chk("r_valid", 16'(if_valid), 16'd0);
    chk("r_if_pc", if_pc, 16'h0000);
    chk("r_plus2", if_pc_plus2, 16'h0000);
    chk("r_ir", if_ir, 16'h0000);
    smp();
    @(posedge clk); #3 reset_n = 1'b1; waits = 0;
    smp();
    chk("r2_read", 16'(imem_read), 16'd1);
    chk("r2_addr", imem_address, 16'h0000);
    step(); smp();
    chk("r2_valid", 16'(if_valid), 16'd1);
    chk("r2_pc", if_pc, 16'h0000);
    chk("r2_addr1", imem_address, 16'h0002);
    step(); smp();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
